pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage pipelined CPU.
- Detects load-use hazards between ID and EX, and flushes IF/ID and ID/EX on a taken branch or jump resolved in EX.
- Sequences a multi-cycle multiply/divide unit: holds dependent HI/LO reads and back-to-back mult/div in ID until the unit is free.
- Keeps saturating stall and flush event counters for performance debug.

Parameters:
- REG_ADDR_W, 5, register-file address width.
- MD_LAT, 4, cycles mult/div occupies HI/LO after issue; must be >= 1.
- CNT_W, 16, width of the stall and flush counters.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- ID_VALID  in  1  ID stage holds a real instruction.
- ID_RS  in  REG_ADDR_W  rs of ID instruction.
- ID_RT  in  REG_ADDR_W  rt of ID instruction.
- ID_USES_RT  in  1  ID instruction reads rt as a source.
- ID_MD_START  in  1  ID instruction is mult/multu/div/divu.
- ID_MD_READ  in  1  ID instruction is mfhi/mflo.
- EX_MEMREAD  in  1  EX instruction is a load.
- EX_RT  in  REG_ADDR_W  destination register of EX load.
- EX_BRANCH_TAKEN  in  1  taken branch or jump resolved in EX.
- PC_WRITE  out  1  PC may update.
- IF_ID_WRITE  out  1  IF/ID register may load.
- IF_ID_FLUSH  out  1  zero IF/ID this cycle.
- ID_EX_BUBBLE  out  1  insert NOP into ID/EX.
- MD_BUSY  out  1  mult/div in flight.
- STALL_CNT  out  CNT_W  number of stall cycles.
- FLUSH_CNT  out  CNT_W  number of flush cycles.

Behaviour:
- Reset (RST_N=0, async), all forced immediately:
  - PC_WRITE=0, IF_ID_WRITE=0, IF_ID_FLUSH=1, ID_EX_BUBBLE=1.
  - MD_BUSY=0, MD counter=0, STALL_CNT=0, FLUSH_CNT=0, FSM=RUN.
- Reset released mid mult/div: the operation is abandoned; MD_BUSY stays 0.
- LU (load-use, combinational) = ID_VALID & EX_MEMREAD & (EX_RT!=0) & ((EX_RT==ID_RS) | (ID_USES_RT & EX_RT==ID_RT)).
- MDH (mult/div hazard, combinational) = ID_VALID & MD_BUSY & (ID_MD_START | ID_MD_READ).
- Output priority, combinational from registered state plus inputs:
  - 1) FLUSH when EX_BRANCH_TAKEN: PC_WRITE=1, IF_ID_WRITE=1, IF_ID_FLUSH=1, ID_EX_BUBBLE=1. Overrides LU/MDH.
  - 2) STALL when LU|MDH: PC_WRITE=0, IF_ID_WRITE=0, IF_ID_FLUSH=0, ID_EX_BUBBLE=1.
  - 3) NORMAL: PC_WRITE=1, IF_ID_WRITE=1, IF_ID_FLUSH=0, ID_EX_BUBBLE=0.
- A load-use stall lasts exactly 1 cycle: next cycle the load is in MEM and EX holds the bubble.
- FSM (registered), with MD_CNT of width clog2(MD_LAT+1):
  - RUN -> MD_WAIT when ACCEPT = ID_VALID & ID_MD_START & no FLUSH & no STALL; MD_CNT <= MD_LAT.
  - MD_WAIT: MD_CNT decrements each cycle; when MD_CNT==1 the next state is RUN, MD_CNT <= 0.
  - MD_BUSY = (state==MD_WAIT), registered.
- Sequential mult/div cases:
  - A mult/div in ID while in MD_WAIT stalls (MDH). It is accepted in the first RUN cycle and re-enters MD_WAIT.
  - A flush in the ACCEPT cycle cancels the accept. A flush during MD_WAIT does not abort the in-flight operation (it is already past ID).
  - mfhi immediately after an accepted mult: exactly MD_LAT stall cycles.
- Counters:
  - STALL_CNT +1 on each STALL cycle; FLUSH_CNT +1 on each FLUSH cycle.
  - Both saturate at all-ones and never wrap.
  - A cycle with branch plus hazard counts as flush only.
- ID_VALID=0 suppresses LU, MDH and ACCEPT; EX_BRANCH_TAKEN still flushes.

Decomposition:
- Shared package hazard_pkg: REG_ZERO constant, FSM state encoding (ST_RUN, ST_MD_WAIT), control-vector constants CTRL_NORMAL/CTRL_STALL/CTRL_FLUSH/CTRL_RESET packing {PC_WRITE, IF_ID_WRITE, IF_ID_FLUSH, ID_EX_BUBBLE}.
- One sub-module: sat_counter (parameter CNT_W; ports CLK, RST_N, INC, COUNT), instantiated twice.

Test Plan:
- Reset: hold RST_N=0 5 cycles, release -> during reset outputs are 0,0,1,1 and counters are 0; first cycle after release with idle inputs gives 1,1,0,0.
- Load-use: EX_MEMREAD=1, EX_RT=8, ID_RS=8 -> one cycle of PC_WRITE=0, IF_ID_WRITE=0, ID_EX_BUBBLE=1, then normal; STALL_CNT=1. Repeat with EX_RT=0 -> no stall.
- Branch with hazard: EX_BRANCH_TAKEN=1 in the same cycle as LU -> IF_ID_FLUSH=1, PC_WRITE=1; FLUSH_CNT=1, STALL_CNT unchanged.
- Mult then mfhi (MD_LAT=4): mult accepted at cycle t, mfhi in ID at t+1 -> MD_BUSY=1 and stall during t+1..t+4, issues at t+5; STALL_CNT=4.
- Flush on mult: branch taken in the mult's ACCEPT cycle -> MD_BUSY stays 0. Asserting RST_N=0 during MD_WAIT -> MD_BUSY=0 asynchronously.
- Saturation: CNT_W=4, hold LU for 20 cycles -> STALL_CNT stops at 15.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared constants, FSM states and control vectors for the hazard controller.
package hazard_pkg;
    localparam int REG_ZERO = 0;

    typedef enum logic {ST_RUN, ST_MD_WAIT} state_t;

    // {PC_WRITE, IF_ID_WRITE, IF_ID_FLUSH, ID_EX_BUBBLE}
    typedef logic [3:0] ctrl_t;
    localparam ctrl_t CTRL_NORMAL = 4'b1100;
    localparam ctrl_t CTRL_STALL  = 4'b0001;
    localparam ctrl_t CTRL_FLUSH  = 4'b1111;
    localparam ctrl_t CTRL_RESET  = 4'b0011;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             INC,
    output logic [CNT_W-1:0] COUNT
);
    always_ff @(posedge CLK or negedge RST_N)
        if (!RST_N) COUNT <= '0;
        else if (INC && !(&COUNT)) COUNT <= COUNT + 1'b1;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use / mult-div stall, branch flush and perf counters for the 5-stage CPU.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int MD_LAT     = 4,
    parameter int CNT_W      = 16
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  ID_VALID,
    input  logic [REG_ADDR_W-1:0] ID_RS,
    input  logic [REG_ADDR_W-1:0] ID_RT,
    input  logic                  ID_USES_RT,
    input  logic                  ID_MD_START,
    input  logic                  ID_MD_READ,
    input  logic                  EX_MEMREAD,
    input  logic [REG_ADDR_W-1:0] EX_RT,
    input  logic                  EX_BRANCH_TAKEN,
    output logic                  PC_WRITE,
    output logic                  IF_ID_WRITE,
    output logic                  IF_ID_FLUSH,
    output logic                  ID_EX_BUBBLE,
    output logic                  MD_BUSY,
    output logic [CNT_W-1:0]      STALL_CNT,
    output logic [CNT_W-1:0]      FLUSH_CNT
);
    localparam int MDC_W = $clog2(MD_LAT + 1);

    state_t           r_state, w_state_nxt;
    logic [MDC_W-1:0] r_md_cnt, w_md_cnt_nxt;
    logic             w_lu, w_mdh, w_flush, w_stall, w_accept;

    assign MD_BUSY  = (r_state == ST_MD_WAIT);
    assign w_lu     = ID_VALID & EX_MEMREAD & (EX_RT != REG_ADDR_W'(REG_ZERO))
                    & ((EX_RT == ID_RS) | (ID_USES_RT & (EX_RT == ID_RT)));
    assign w_mdh    = ID_VALID & MD_BUSY & (ID_MD_START | ID_MD_READ);
    assign w_flush  = EX_BRANCH_TAKEN;
    assign w_stall  = ~w_flush & (w_lu | w_mdh);
    assign w_accept = ID_VALID & ID_MD_START & ~w_flush & ~w_stall;

    // Reset drives the controls directly so the pipeline is held even before the first clock.
    assign {PC_WRITE, IF_ID_WRITE, IF_ID_FLUSH, ID_EX_BUBBLE} =
        !RST_N  ? CTRL_RESET :
        w_flush ? CTRL_FLUSH :
        w_stall ? CTRL_STALL : CTRL_NORMAL;

    always_ff @(posedge CLK or negedge RST_N)
        if (!RST_N) begin
            r_state  <= ST_RUN;
            r_md_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_md_cnt <= w_md_cnt_nxt;
        end

    always_comb begin
        w_state_nxt  = r_state;
        w_md_cnt_nxt = r_md_cnt;
        if (r_state == ST_RUN) begin
            if (w_accept) begin
                w_state_nxt  = ST_MD_WAIT;
                w_md_cnt_nxt = MDC_W'(MD_LAT);
            end
        end else if (r_md_cnt == MDC_W'(1)) begin
            w_state_nxt  = ST_RUN;
            w_md_cnt_nxt = '0;
        end else begin
            w_md_cnt_nxt = r_md_cnt - 1'b1;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (.CLK(CLK), .RST_N(RST_N), .INC(w_stall), .COUNT(STALL_CNT));
    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (.CLK(CLK), .RST_N(RST_N), .INC(w_flush), .COUNT(FLUSH_CNT));
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed and random checks of the hazard controller against a cycle-level model.
module tb_pipeline_hazard_ctrl;
    localparam int MD_LAT = 4;

    logic       CLK = 0, RST_N = 1;
    logic       ID_VALID = 0, ID_USES_RT = 0, ID_MD_START = 0, ID_MD_READ = 0;
    logic       EX_MEMREAD = 0, EX_BRANCH_TAKEN = 0;
    logic [4:0] ID_RS = 0, ID_RT = 0, EX_RT = 0;

    logic        pcw_a, ifw_a, iff_a, bub_a, busy_a;
    logic        pcw_b, ifw_b, iff_b, bub_b, busy_b;
    logic [15:0] sc_a, fc_a;
    logic [3:0]  sc_b, fc_b;

    int checks = 0, errors = 0;
    int rem = 0, scnt = 0, fcnt = 0;

    always #5 CLK = ~CLK;

    pipeline_hazard_ctrl #(.REG_ADDR_W(5), .MD_LAT(MD_LAT), .CNT_W(16)) dut_a (
        .CLK(CLK), .RST_N(RST_N), .ID_VALID(ID_VALID), .ID_RS(ID_RS), .ID_RT(ID_RT),
        .ID_USES_RT(ID_USES_RT), .ID_MD_START(ID_MD_START), .ID_MD_READ(ID_MD_READ),
        .EX_MEMREAD(EX_MEMREAD), .EX_RT(EX_RT), .EX_BRANCH_TAKEN(EX_BRANCH_TAKEN),
        .PC_WRITE(pcw_a), .IF_ID_WRITE(ifw_a), .IF_ID_FLUSH(iff_a), .ID_EX_BUBBLE(bub_a),
        .MD_BUSY(busy_a), .STALL_CNT(sc_a), .FLUSH_CNT(fc_a));

    pipeline_hazard_ctrl #(.REG_ADDR_W(5), .MD_LAT(MD_LAT), .CNT_W(4)) dut_b (
        .CLK(CLK), .RST_N(RST_N), .ID_VALID(ID_VALID), .ID_RS(ID_RS), .ID_RT(ID_RT),
        .ID_USES_RT(ID_USES_RT), .ID_MD_START(ID_MD_START), .ID_MD_READ(ID_MD_READ),
        .EX_MEMREAD(EX_MEMREAD), .EX_RT(EX_RT), .EX_BRANCH_TAKEN(EX_BRANCH_TAKEN),
        .PC_WRITE(pcw_b), .IF_ID_WRITE(ifw_b), .IF_ID_FLUSH(iff_b), .ID_EX_BUBBLE(bub_b),
        .MD_BUSY(busy_b), .STALL_CNT(sc_b), .FLUSH_CNT(fc_b));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit m_flush();
        return RST_N && EX_BRANCH_TAKEN;
    endfunction

    function automatic bit m_stall();
        bit lu, mdh;
        lu  = ID_VALID && EX_MEMREAD && EX_RT != 0 && (EX_RT == ID_RS || (ID_USES_RT && EX_RT == ID_RT));
        mdh = ID_VALID && rem > 0 && (ID_MD_START || ID_MD_READ);
        return RST_N && !m_flush() && (lu || mdh);
    endfunction

    function automatic logic [3:0] m_ctrl();
        return !RST_N ? 4'b0011 : m_flush() ? 4'b1111 : m_stall() ? 4'b0001 : 4'b1100;
    endfunction

    task automatic compare();
        int s16, f16, s4, f4;
        s16 = !RST_N ? 0 : scnt > 65535 ? 65535 : scnt;
        f16 = !RST_N ? 0 : fcnt > 65535 ? 65535 : fcnt;
        s4  = !RST_N ? 0 : scnt > 15 ? 15 : scnt;
        f4  = !RST_N ? 0 : fcnt > 15 ? 15 : fcnt;
        chk("ctrl_a", {pcw_a, ifw_a, iff_a, bub_a}, m_ctrl());
        chk("ctrl_b", {pcw_b, ifw_b, iff_b, bub_b}, m_ctrl());
        chk("busy_a", busy_a, RST_N && rem > 0);
        chk("busy_b", busy_b, RST_N && rem > 0);
        chk("stall_cnt_a", sc_a, s16);
        chk("flush_cnt_a", fc_a, f16);
        chk("stall_cnt_b", sc_b, s4);
        chk("flush_cnt_b", fc_b, f4);
    endtask

    task automatic step();
        #2;
        compare();
    endtask

    task automatic adv();
        bit f, s, acc;
        @(posedge CLK);
        if (!RST_N) begin
            rem = 0; scnt = 0; fcnt = 0;
        end else begin
            f   = m_flush();
            s   = m_stall();
            acc = ID_VALID && ID_MD_START && !f && !s;
            if (f) fcnt++;
            else if (s) scnt++;
            rem = acc ? MD_LAT : (rem > 0 ? rem - 1 : 0);
        end
        #1;
    endtask

    task automatic idle();
        ID_VALID = 0; ID_USES_RT = 0; ID_MD_START = 0; ID_MD_READ = 0;
        EX_MEMREAD = 0; EX_BRANCH_TAKEN = 0; ID_RS = 0; ID_RT = 0; EX_RT = 0;
    endtask

    initial begin
        #2 RST_N = 0;
        @(posedge CLK); #1;
        repeat (5) begin
            step();
            chk("rst_ctrl", {pcw_a, ifw_a, iff_a, bub_a}, 4'b0011);
            chk("rst_cnt", {sc_a, fc_a}, 0);
            adv();
        end
        RST_N = 1;
        step(); chk("post_rst_ctrl", {pcw_a, ifw_a, iff_a, bub_a}, 4'b1100); adv();

        ID_VALID = 1; ID_RS = 8; EX_MEMREAD = 1; EX_RT = 8;
        step(); chk("lu_stall", {pcw_a, ifw_a, iff_a, bub_a}, 4'b0001); adv();
        EX_MEMREAD = 0;
        step(); chk("lu_release", {pcw_a, ifw_a, iff_a, bub_a}, 4'b1100); chk("lu_cnt", sc_a, 1); adv();
        EX_MEMREAD = 1; EX_RT = 0; ID_RS = 0;
        step(); chk("lu_r0", {pcw_a, ifw_a, iff_a, bub_a}, 4'b1100); adv();

        EX_RT = 8; ID_RS = 8; EX_BRANCH_TAKEN = 1;
        step(); chk("br_lu", {pcw_a, ifw_a, iff_a, bub_a}, 4'b1111); adv();
        idle();
        step(); chk("br_fcnt", fc_a, 1); chk("br_scnt", sc_a, 1); adv();

        ID_VALID = 1; ID_MD_START = 1;
        step(); chk("mult_acc", {pcw_a, ifw_a, iff_a, bub_a, busy_a}, 5'b11000); adv();
        ID_MD_START = 0; ID_MD_READ = 1;
        for (int i = 0; i < MD_LAT; i++) begin
            step(); chk("mfhi_stall", {pcw_a, ifw_a, iff_a, bub_a, busy_a}, 5'b00011); adv();
        end
        step(); chk("mfhi_issue", {pcw_a, ifw_a, iff_a, bub_a, busy_a}, 5'b11000); chk("mfhi_cnt", sc_a, 5); adv();

        ID_MD_READ = 0; ID_MD_START = 1; EX_BRANCH_TAKEN = 1;
        step(); adv();
        ID_MD_START = 0; EX_BRANCH_TAKEN = 0;
        step(); chk("flush_mult_busy", busy_a, 0); adv();

        ID_MD_START = 1;
        step(); adv();
        idle();
        step(); chk("md_wait_busy", busy_a, 1); adv();
        RST_N = 0;
        #1 chk("async_rst_busy", busy_a, 0);
        step(); adv();
        RST_N = 1;
        step(); chk("abandoned_busy", busy_a, 0); adv();

        ID_VALID = 1; ID_RS = 8; EX_MEMREAD = 1; EX_RT = 8;
        repeat (20) begin step(); adv(); end
        idle();
        step(); chk("sat_b", sc_b, 15); chk("sat_a", sc_a, 20); adv();

        repeat (800) begin
            RST_N           = $urandom_range(0, 99) != 0;
            ID_VALID        = $urandom_range(0, 7) != 0;
            ID_RS           = 5'($urandom_range(0, 3));
            ID_RT           = 5'($urandom_range(0, 3));
            EX_RT           = 5'($urandom_range(0, 3));
            ID_USES_RT      = 1'($urandom_range(0, 1));
            ID_MD_START     = $urandom_range(0, 5) == 0;
            ID_MD_READ      = $urandom_range(0, 4) == 0;
            EX_MEMREAD      = $urandom_range(0, 2) == 0;
            EX_BRANCH_TAKEN = $urandom_range(0, 7) == 0;
            step(); adv();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
